// File: rtl/common_ram_stream_fifo_ctrl.sv
// rtl/common_ram_stream_fifo_ctrl.sv - valid/ready stream FIFO controller driving a true dual-port RAM
// Define RAM_STREAM_FIFO_LEVEL_EN to add the registered fill-level output port.
module common_ram_stream_fifo_ctrl #(
  parameter int    DATA_WIDTH     = 8,
  parameter int    ADDR_WIDTH     = 9,
  parameter string RAM_OUTPUT_REG = "FALSE"
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  ram_we1,
  output logic [ADDR_WIDTH-1:0] ram_addr1,
  output logic [DATA_WIDTH-1:0] ram_din1,
  output logic                  ram_we2,
  output logic [ADDR_WIDTH-1:0] ram_addr2,
  input  logic [DATA_WIDTH-1:0] ram_dout2,
  output logic                  full,
  output logic                  empty
`ifdef RAM_STREAM_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH+1:0] level
`endif
);

  localparam int RD_LAT     = (RAM_OUTPUT_REG == "TRUE") ? 2 : 1;
  localparam int OBUF_DEPTH = RD_LAT + 1;
  localparam int IW         = (OBUF_DEPTH > 2) ? 2 : 1;

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [IW-1:0]       OBUF_LAST  = IW'(OBUF_DEPTH - 1);
  localparam logic [2:0]          OBUF_SLOTS = 3'(OBUF_DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
  logic [RD_LAT-1:0]     pipe_q, pipe_d;
  logic [RD_LAT:0]       pipe_shift;
  logic [DATA_WIDTH-1:0] obuf_q [OBUF_DEPTH];
  logic [IW-1:0]         head_q, head_d;
  logic [IW-1:0]         tail_q, tail_d;
  logic [1:0]            obuf_cnt_q, obuf_cnt_d;
  logic [1:0]            inflight_cnt;
  logic [2:0]            pending;
  logic                  wr, rd_iss, push, pop;

  function automatic logic [IW-1:0] obuf_inc(input logic [IW-1:0] p);
    return (p == OBUF_LAST) ? '0 : p + IW'(1);
  endfunction

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_cnt = inflight_cnt + {1'b0, pipe_q[i]};
    end
  end

  assign full    = (ram_cnt_q == DEPTH_CNT);
  assign s_ready = !full;
  assign wr      = s_valid & s_ready;
  assign m_valid = (obuf_cnt_q != '0);
  assign m_data  = obuf_q[head_q];
  assign pop     = m_valid & m_ready;
  assign push    = pipe_q[RD_LAT-1];

  // A pop this cycle frees a slot, so it is credited before deciding to issue;
  // without it the output stalls every third cycle.
  assign pending = {1'b0, obuf_cnt_q} + {1'b0, inflight_cnt} - {2'b00, pop};
  assign rd_iss  = (ram_cnt_q != '0) && (pending < OBUF_SLOTS);

  assign ram_we1   = wr;
  assign ram_addr1 = wr_ptr_q;
  assign ram_din1  = s_data;
  assign ram_we2   = 1'b0;
  assign ram_addr2 = rd_ptr_q;
  assign empty     = (ram_cnt_q == '0) && (inflight_cnt == '0) && (obuf_cnt_q == '0);

  assign pipe_shift = {pipe_q, rd_iss};

  always_comb begin
    wr_ptr_d   = wr ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d   = rd_iss ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    if (wr && !rd_iss) begin
      ram_cnt_d = ram_cnt_q + (ADDR_WIDTH+1)'(1);
    end else if (!wr && rd_iss) begin
      ram_cnt_d = ram_cnt_q - (ADDR_WIDTH+1)'(1);
    end
    pipe_d     = pipe_shift[RD_LAT-1:0];
    head_d     = pop ? obuf_inc(head_q) : head_q;
    tail_d     = push ? obuf_inc(tail_q) : tail_q;
    obuf_cnt_d = obuf_cnt_q;
    if (push && !pop) begin
      obuf_cnt_d = obuf_cnt_q + 2'd1;
    end else if (!push && pop) begin
      obuf_cnt_d = obuf_cnt_q - 2'd1;
    end
    // Flush abandons any read still inside the RAM; its data is never captured.
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      ram_cnt_d  = '0;
      pipe_d     = '0;
      head_d     = '0;
      tail_d     = '0;
      obuf_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      pipe_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      obuf_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      pipe_q     <= pipe_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      obuf_cnt_q <= obuf_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        obuf_q[i] <= '0;
      end
    end else if (push) begin
      obuf_q[tail_q] <= ram_dout2;
    end
  end

`ifdef RAM_STREAM_FIFO_LEVEL_EN
  logic [ADDR_WIDTH+1:0] level_q, level_d;

  always_comb begin
    level_d = level_q;
    if (wr && !pop) begin
      level_d = level_q + (ADDR_WIDTH+2)'(1);
    end else if (!wr && pop) begin
      level_d = level_q - (ADDR_WIDTH+2)'(1);
    end
    if (clr) begin
      level_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level = level_q;
`endif

endmodule

// File: tb/tb_common_ram_stream_fifo_ctrl.sv
// tb/tb_common_ram_stream_fifo_ctrl.sv - randomized scoreboard bench for the RAM stream FIFO controller
// Honours RAM_STREAM_FIFO_LEVEL_EN when defined.
module tb_common_ram_stream_fifo_ctrl;

  localparam int    DW         = 8;
  localparam int    AW         = 4;
  localparam int    DEPTH      = 16;
  localparam string ROR        = "FALSE";
  localparam int    RD_LAT     = (ROR == "TRUE") ? 2 : 1;
  localparam int    OBUF_DEPTH = RD_LAT + 1;
  localparam int    CAP        = DEPTH + OBUF_DEPTH;
  localparam int    NWORDS     = 10000;

  logic          clk;
  logic          rstn;
  logic          clr;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          ram_we1;
  logic [AW-1:0] ram_addr1;
  logic [DW-1:0] ram_din1;
  logic          ram_we2;
  logic [AW-1:0] ram_addr2;
  logic [DW-1:0] ram_dout2;
  logic          full;
  logic          empty;
`ifdef RAM_STREAM_FIFO_LEVEL_EN
  logic [AW+1:0] level;
`endif

  common_ram_stream_fifo_ctrl #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .RAM_OUTPUT_REG (ROR)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (clr),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .ram_we1   (ram_we1),
    .ram_addr1 (ram_addr1),
    .ram_din1  (ram_din1),
    .ram_we2   (ram_we2),
    .ram_addr2 (ram_addr2),
    .ram_dout2 (ram_dout2),
    .full      (full),
    .empty     (empty)
`ifdef RAM_STREAM_FIFO_LEVEL_EN
    ,
    .level     (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: port 1 writes, port 2 reads with RD_LAT registered stages.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd1, rd2;
  always @(posedge clk) begin
    if (ram_we1) mem[ram_addr1] <= ram_din1;
    rd1 <= mem[ram_addr2];
    rd2 <= rd1;
  end
  assign ram_dout2 = (RD_LAT == 2) ? rd2 : rd1;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] q[$];
  int            wr_cnt   = 0;
  int            n_pop    = 0;
  logic          hold_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    wr_cnt    = 0;
    hold_prev = 1'b0;
  endtask

  // One clock: check outputs at the falling edge, then commit handshakes to the model.
  task automatic step();
    logic          acc, pop, clr_s, hold_n;
    logic [DW-1:0] din;
    @(negedge clk);
    check_eq("empty", 32'(empty), 32'(q.size() == 0));
    check_eq("ram_we2", 32'(ram_we2), 32'(0));
    if (q.size() < DEPTH) begin
      check_eq("s_ready_room", 32'(s_ready), 32'(1));
      check_eq("full_room", 32'(full), 32'(0));
    end
    if (q.size() >= CAP) begin
      check_eq("s_ready_cap", 32'(s_ready), 32'(0));
      check_eq("full_cap", 32'(full), 32'(1));
    end
    if (q.size() == 0) check_eq("m_valid_idle", 32'(m_valid), 32'(0));
    else if (m_valid) check_eq("m_data", 32'(m_data), 32'(q[0]));
    if (hold_prev) check_eq("m_hold", 32'(m_valid), 32'(1));
    acc = s_valid && s_ready;
    pop = m_valid && m_ready && (q.size() > 0);
    check_eq("ram_we1", 32'(ram_we1), 32'(acc));
    if (acc) begin
      check_eq("ram_addr1", 32'(ram_addr1), 32'(wr_cnt % DEPTH));
      check_eq("ram_din1", 32'(ram_din1), 32'(s_data));
    end
`ifdef RAM_STREAM_FIFO_LEVEL_EN
    check_eq("level", 32'(level), 32'(q.size()));
`endif
    clr_s  = clr;
    hold_n = m_valid && !m_ready;
    din    = s_data;
    @(posedge clk);
    #1;
    if (clr_s) begin
      model_clear();
    end else begin
      if (pop) begin
        void'(q.pop_front());
        n_pop++;
      end
      if (acc) begin
        q.push_back(din);
        wr_cnt++;
      end
      hold_prev = hold_n;
    end
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    clr     = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    model_clear();
  endtask

  int            lat, gaps, wraps, p0, nxt;
  logic          started;
  logic [AW-1:0] a2;

  initial begin
    rstn = 1'b0; clr = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    do_reset();
    check_eq("rst_s_ready", 32'(s_ready), 32'(1));
    check_eq("rst_m_valid", 32'(m_valid), 32'(0));
    check_eq("rst_empty", 32'(empty), 32'(1));
    check_eq("rst_full", 32'(full), 32'(0));
    check_eq("rst_addr1", 32'(ram_addr1), 32'(0));
    check_eq("rst_addr2", 32'(ram_addr2), 32'(0));

    // Single word latency.
    m_ready = 1'b1; s_valid = 1'b1; s_data = 8'hA5;
    step();
    s_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      if (m_valid && lat == 0) begin
        lat = k;
        check_eq("lat_data", 32'(m_data), 32'(8'hA5));
      end
      step();
    end
    check_eq("latency", 32'(lat), 32'(2 + RD_LAT));

    // Fill with the consumer stalled, then drain without gaps.
    do_reset();
    nxt = 0;
    for (int c = 0; c < 40; c++) begin
      s_valid = (nxt <= 30);
      s_data  = 8'(nxt);
      if (s_valid && s_ready) nxt++;
      step();
    end
    check_eq("fill_accepts", 32'(wr_cnt), 32'(CAP));
    check_eq("fill_full", 32'(full), 32'(1));
    check_eq("fill_s_ready", 32'(s_ready), 32'(0));
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < CAP; i++) begin
      check_eq("fill_no_gap", 32'(m_valid), 32'(1));
      step();
    end
    step();
    check_eq("fill_drained", 32'(empty), 32'(1));

    // Three RAM depths at full rate: pointer wrap and sustained throughput.
    do_reset();
    m_ready = 1'b1; gaps = 0; wraps = 0; started = 1'b0; p0 = n_pop;
    for (int c = 0; c < 300 && (n_pop - p0) < 3 * DEPTH; c++) begin
      s_valid = (wr_cnt < 3 * DEPTH);
      s_data  = 8'($urandom);
      if (m_valid) started = 1'b1;
      else if (started) gaps++;
      a2 = ram_addr2;
      step();
      if (a2 == 4'hF && ram_addr2 == 4'h0) wraps++;
    end
    check_eq("wrap_words", 32'(n_pop - p0), 32'(3 * DEPTH));
    check_eq("wrap_gaps", 32'(gaps), 32'(0));
    check_eq("wrap_rd_wraps", 32'(wraps), 32'(3));

    // Asynchronous reset in the middle of a stream.
    m_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h40 + i);
      step();
    end
    s_valid = 1'b0;
    #3 rstn = 1'b0;
    #1;
    check_eq("mid_rst_s_ready", 32'(s_ready), 32'(1));
    check_eq("mid_rst_m_valid", 32'(m_valid), 32'(0));
    check_eq("mid_rst_empty", 32'(empty), 32'(1));
    check_eq("mid_rst_full", 32'(full), 32'(0));
    check_eq("mid_rst_addr1", 32'(ram_addr1), 32'(0));
    check_eq("mid_rst_addr2", 32'(ram_addr2), 32'(0));
    @(posedge clk);
    #1 rstn = 1'b1;
    model_clear();

    // Random traffic with phased backpressure.
    p0 = n_pop;
    for (int c = 0; c < 40000 && (n_pop - p0) < NWORDS; c++) begin
      s_valid = (wr_cnt < NWORDS) && ($urandom_range(0, 3) != 0);
      s_data  = 8'($urandom);
      case ((c / 256) % 3)
        0:       m_ready = ($urandom_range(0, 3) == 0);
        1:       m_ready = ($urandom_range(0, 3) != 0);
        default: m_ready = 1'b1;
      endcase
      step();
    end
    s_valid = 1'b0;
    check_eq("rand_words", 32'(n_pop - p0), 32'(NWORDS));

    // Synchronous flush with words stored.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      step();
    end
    s_valid = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_eq("clr_empty", 32'(empty), 32'(1));
    check_eq("clr_m_valid", 32'(m_valid), 32'(0));
`ifdef RAM_STREAM_FIFO_LEVEL_EN
    check_eq("clr_level", 32'(level), 32'(0));
`endif
    m_ready = 1'b1;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
